alu_seq: RTL and testbench

//  Parametrised multi-cycle ALU for the LC-3b datapath; successor to the combinational ALU.

---
 rtl/alu_seq.sv | 173 +++++++++++++++++
 tb/tb_alu_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle LC-3b ALU; add/and/not/pass in one cycle, sll/srl/sra iterate SHIFT_STEP bits per cycle.
// Latency: 1 cycle (single-cycle ops, zero-amount shifts), 1+ceil(n/SHIFT_STEP) for shifts, WIDTH+1 for mul.
// Backpressure: no queueing; start_i is sampled only while busy_o=0 and is dropped while busy_o=1.
//
// Optional feature macro: ALU_MUL_EN. When defined, aluop 111 runs an unsigned shift-add multiply
// (one multiplier bit per cycle). When undefined, aluop 111 is illegal: f_o=0, err_o=1, done_o at T+1.
//
// Ports:
//   clk_i    clock, all state updates on posedge
//   reset_i  synchronous active-high reset; aborts any op in flight without a done pulse
//   start_i  launch an op (ignored while busy_o=1)
//   aluop_i  000 add, 001 and, 010 not, 011 pass, 100 sll, 101 srl, 110 sra, 111 mul
//   a_i      operand A (shifted value / multiplicand)
//   b_i      operand B (shift amount taken from its low $clog2(WIDTH) bits / multiplier)
//   busy_o   multi-cycle op in flight
//   done_o   one-cycle pulse; f_o and err_o valid from this cycle
//   f_o      registered result, held until the next done
//   err_o    set with done for an illegal op, cleared at the next accepted start
module alu_seq #(
    parameter int WIDTH      = 16,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [2:0]       aluop_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] f_o,
    output logic             err_o
);
    localparam int SW = $clog2(WIDTH);
    // One extra bit so SHIFT_STEP == WIDTH is representable in the comparison below.
    localparam logic [SW:0] STEP_W = SHIFT_STEP[SW:0];

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_SLL  = 3'b100;
    localparam logic [2:0] OP_SRL  = 3'b101;
    localparam logic [2:0] OP_SRA  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_e;
`endif

    state_e           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] acc_q, acc_d;     // value being shifted (also the multiplicand)
    logic [SW-1:0]    cnt_q, cnt_d;     // remaining shift amount / remaining mul steps
    logic             busy_q, done_q, err_q;
    logic [WIDTH-1:0] f_q;
    logic [WIDTH-1:0] quick_d;
    logic [SW-1:0]    amt;
    logic [SW-1:0]    step_k;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] prod_q, prod_d;
    assign prod_d = prod_q + (mplier_q[0] ? acc_q : '0);
`endif

    assign amt = b_i[SW-1:0];

    // Bits shifted this cycle: min(remaining, SHIFT_STEP).
    assign step_k = ({1'b0, cnt_q} < STEP_W) ? cnt_q : STEP_W[SW-1:0];
    assign cnt_d  = cnt_q - step_k;

    always_comb begin
        acc_d = acc_q;
        case (op_q)
            OP_SLL:  acc_d = acc_q << step_k;
            OP_SRL:  acc_d = acc_q >> step_k;
            OP_SRA:  acc_d = $signed(acc_q) >>> step_k;
            default: acc_d = acc_q;
        endcase
    end

    // Result of ops that finish in the accept cycle; zero-amount shifts pass A through.
    always_comb begin
        quick_d = a_i;
        case (aluop_i)
            OP_ADD:  quick_d = a_i + b_i;
            OP_AND:  quick_d = a_i & b_i;
            OP_NOT:  quick_d = ~a_i;
            default: quick_d = a_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            f_q      <= '0;
`ifdef ALU_MUL_EN
            mplier_q <= '0;
            prod_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        op_q  <= aluop_i;
                        acc_q <= a_i;
                        cnt_q <= amt;
                        err_q <= 1'b0;
                        if (aluop_i == OP_MUL) begin
`ifdef ALU_MUL_EN
                            mplier_q <= b_i;
                            prod_q   <= '0;
                            cnt_q    <= '1;     // WIDTH steps: counts WIDTH-1 down to 0
                            busy_q   <= 1'b1;
                            state_q  <= S_MUL;
`else
                            f_q    <= '0;
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
`endif
                        end else if (aluop_i[2] && (amt != '0)) begin
                            busy_q  <= 1'b1;
                            state_q <= S_SHIFT;
                        end else begin
                            f_q    <= quick_d;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                    if (cnt_d == '0) begin
                        f_q     <= acc_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
`ifdef ALU_MUL_EN
                S_MUL: begin
                    acc_q    <= acc_q << 1;
                    mplier_q <= mplier_q >> 1;
                    prod_q   <= prod_d;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        f_q     <= prod_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign f_o    = f_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  aluop;
    logic [15:0] a, b;
    logic        busy1, done1, err1;
    logic [15:0] f1;
    logic        busy4, done4, err4;
    logic [15:0] f4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(16), .SHIFT_STEP(1)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .aluop_i(aluop), .a_i(a), .b_i(b),
        .busy_o(busy1), .done_o(done1), .f_o(f1), .err_o(err1));

    alu_seq #(.WIDTH(16), .SHIFT_STEP(4)) dut4 (
        .clk_i(clk), .reset_i(reset), .start_i(start), .aluop_i(aluop), .a_i(a), .b_i(b),
        .busy_o(busy4), .done_o(done4), .f_o(f4), .err_o(err4));

    // Reference model: results from arithmetic on the operand values.
    function automatic logic [15:0] model_f(input logic [2:0] op, input logic [15:0] av, input logic [15:0] bv);
        int          n;
        longint      p2;
        logic [15:0] inv;
        n   = int'(bv) % 16;
        p2  = longint'(1) << n;
        inv = ~av;
        case (op)
            3'd0: return 16'((longint'(av) + longint'(bv)) % 65536);
            3'd1: return av & bv;
            3'd2: return inv;
            3'd3: return av;
            3'd4: return 16'((longint'(av) * p2) % 65536);
            3'd5: return 16'(longint'(av) / p2);
            3'd6: return av[15] ? 16'(~(longint'(inv) / p2)) : 16'(longint'(av) / p2);
            default: return MUL_EN ? 16'((longint'(av) * longint'(bv)) % 65536) : 16'h0000;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [15:0] bv, input int step);
        int n;
        n = int'(bv) % 16;
        if (op >= 3'd4 && op <= 3'd6) return (n == 0) ? 1 : 1 + (n + step - 1) / step;
        if (op == 3'd7) return MUL_EN ? 17 : 1;
        return 1;
    endfunction

    // Issues one op, scrambles inputs afterwards, and observes both DUTs until done (bounded).
    task automatic run_op(input logic [2:0] op, input logic [15:0] av, input logic [15:0] bv,
                          output int lat1, output int lat4, output logic [15:0] r1, output logic [15:0] r4,
                          output logic e1, output logic e4, output int bz1, output int bz4,
                          output int dn1, output int dn4);
        lat1 = -1; lat4 = -1; r1 = 'x; r4 = 'x; e1 = 1'bx; e4 = 1'bx;
        bz1 = 0; bz4 = 0; dn1 = 0; dn4 = 0;
        @(negedge clk);
        start = 1'b1; aluop = op; a = av; b = bv;
        @(posedge clk);
        #1;
        start = 1'b0; aluop = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done1) begin dn1++; if (lat1 < 0) begin lat1 = c; r1 = f1; e1 = err1; end end
            if (done4) begin dn4++; if (lat4 < 0) begin lat4 = c; r4 = f4; e4 = err4; end end
            if (busy1 && lat1 < 0) bz1++;
            if (busy4 && lat4 < 0) bz4++;
            if (lat1 >= 0 && lat4 >= 0 && c > lat1 && c > lat4) break;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1; start = 1'b1; aluop = 3'b000; a = 16'h0005; b = 16'h0006;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy1); end
        checks++; if (f1 !== 16'h0000) begin errors++; $display("FAIL reset_f got=%h want=0000", f1); end
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err1); end
        @(negedge clk);
        checks++; if ({done1, done4, busy4, err4} !== 4'b0000) begin errors++; $display("FAIL reset_after got=%b want=0000", {done1, done4, busy4, err4}); end
    endtask

    task automatic test_add_not;
        @(negedge clk);
        start = 1'b1; aluop = 3'b000; a = 16'hFFFF; b = 16'h0002;
        @(negedge clk);
        checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL add_done got=%b want=1", done1); end
        checks++; if (f1 !== 16'h0001) begin errors++; $display("FAIL add_f got=%h want=0001", f1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL add_busy got=%b want=0", busy1); end
        aluop = 3'b010; a = 16'h00F0; b = 16'h1234;
        @(negedge clk);
        start = 1'b0;
        checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL not_done got=%b want=1", done1); end
        checks++; if (f1 !== 16'hFF0F) begin errors++; $display("FAIL not_f got=%h want=ff0f", f1); end
        @(negedge clk);
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL not_single_pulse got=%b want=0", done1); end
        checks++; if (f1 !== 16'hFF0F) begin errors++; $display("FAIL not_hold got=%h want=ff0f", f1); end
    endtask

    task automatic test_sra;
        int l1, l4, z1, z4, d1, d4; logic [15:0] r1, r4; logic e1, e4;
        run_op(3'b110, 16'h8000, 16'h0004, l1, l4, r1, r4, e1, e4, z1, z4, d1, d4);
        checks++; if (l1 !== 5) begin errors++; $display("FAIL sra_lat got=%0d want=5", l1); end
        checks++; if (z1 !== 4) begin errors++; $display("FAIL sra_busy_cycles got=%0d want=4", z1); end
        checks++; if (r1 !== 16'hF800) begin errors++; $display("FAIL sra_f got=%h want=f800", r1); end
        checks++; if (l4 !== 2) begin errors++; $display("FAIL sra_step4_lat got=%0d want=2", l4); end
        checks++; if (r4 !== 16'hF800) begin errors++; $display("FAIL sra_step4_f got=%h want=f800", r4); end
    endtask

    task automatic test_shift_zero;
        int l1, l4, z1, z4, d1, d4; logic [15:0] r1, r4; logic e1, e4;
        run_op(3'b101, 16'hA5C3, 16'h0000, l1, l4, r1, r4, e1, e4, z1, z4, d1, d4);
        checks++; if (l1 !== 1) begin errors++; $display("FAIL srl0_lat got=%0d want=1", l1); end
        checks++; if (r1 !== 16'hA5C3) begin errors++; $display("FAIL srl0_f got=%h want=a5c3", r1); end
        checks++; if (z1 !== 0) begin errors++; $display("FAIL srl0_busy got=%0d want=0", z1); end
        run_op(3'b100, 16'h1234, 16'h0010, l1, l4, r1, r4, e1, e4, z1, z4, d1, d4);
        checks++; if (l1 !== 1) begin errors++; $display("FAIL sll16_lat got=%0d want=1", l1); end
        checks++; if (r1 !== 16'h1234) begin errors++; $display("FAIL sll16_f got=%h want=1234", r1); end
    endtask

    task automatic test_busy_drop;
        int d1, d4;
        d1 = 0; d4 = 0;
        @(negedge clk);
        start = 1'b1; aluop = 3'b100; a = 16'h0001; b = 16'h000F;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (done1) d1++;
            if (done4) d4++;
            start = (c == 2 || c == 3); aluop = 3'b000; a = 16'h1111; b = 16'h2222;
        end
        start = 1'b0;
        checks++; if (d1 !== 1) begin errors++; $display("FAIL drop_dones got=%0d want=1", d1); end
        checks++; if (d4 !== 1) begin errors++; $display("FAIL drop_dones_step4 got=%0d want=1", d4); end
        checks++; if (f1 !== 16'h8000) begin errors++; $display("FAIL drop_f got=%h want=8000", f1); end
    endtask

    task automatic test_reset_mid;
        int d, l1, l4, z1, z4, d1, d4; logic [15:0] r1, r4; logic e1, e4;
        d = 0;
        @(negedge clk);
        start = 1'b1; aluop = 3'b100; a = 16'h0001; b = 16'h000F;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (done1 || done4) d++;
            if (c == 3) reset = 1'b1;
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if ({busy1, done1, err1} !== 3'b000) begin errors++; $display("FAIL rstmid_ctrl got=%b want=000", {busy1, done1, err1}); end
        checks++; if (f1 !== 16'h0000) begin errors++; $display("FAIL rstmid_f got=%h want=0000", f1); end
        checks++; if ({busy4, f4} !== 17'h0) begin errors++; $display("FAIL rstmid_step4 got=%h want=0", {busy4, f4}); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done1 || done4) d++;
        end
        checks++; if (d !== 0) begin errors++; $display("FAIL rstmid_no_done got=%0d want=0", d); end
        run_op(3'b100, 16'h0003, 16'h0002, l1, l4, r1, r4, e1, e4, z1, z4, d1, d4);
        checks++; if (r1 !== 16'h000C) begin errors++; $display("FAIL rstmid_next_f got=%h want=000c", r1); end
        checks++; if (l1 !== 3) begin errors++; $display("FAIL rstmid_next_lat got=%0d want=3", l1); end
    endtask

    task automatic test_mul;
        int l1, l4, z1, z4, d1, d4; logic [15:0] r1, r4; logic e1, e4;
        run_op(3'b111, 16'd300, 16'd300, l1, l4, r1, r4, e1, e4, z1, z4, d1, d4);
        checks++; if (l1 !== (MUL_EN ? 17 : 1)) begin errors++; $display("FAIL mul_lat got=%0d want=%0d", l1, MUL_EN ? 17 : 1); end
        checks++; if (r1 !== (MUL_EN ? 16'h5F90 : 16'h0000)) begin errors++; $display("FAIL mul_f got=%h want=%h", r1, MUL_EN ? 16'h5F90 : 16'h0000); end
        checks++; if (e1 !== !MUL_EN) begin errors++; $display("FAIL mul_err got=%b want=%b", e1, !MUL_EN); end
        run_op(3'b001, 16'hF0F0, 16'h3C3C, l1, l4, r1, r4, e1, e4, z1, z4, d1, d4);
        checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL err_clear got=%b want=0", e1); end
        checks++; if (r1 !== 16'h3030) begin errors++; $display("FAIL and_f got=%h want=3030", r1); end
    endtask

    task automatic test_step4;
        int l1, l4, z1, z4, d1, d4; logic [15:0] r1, r4; logic e1, e4;
        run_op(3'b100, 16'h0001, 16'h0009, l1, l4, r1, r4, e1, e4, z1, z4, d1, d4);
        checks++; if (l4 !== 4) begin errors++; $display("FAIL step4_lat got=%0d want=4", l4); end
        checks++; if (r4 !== 16'h0200) begin errors++; $display("FAIL step4_f got=%h want=0200", r4); end
        checks++; if (l1 !== 10) begin errors++; $display("FAIL step1_lat got=%0d want=10", l1); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_f;
        exp_f = 'x;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++; if (done1 !== 1'b1 || f1 !== exp_f) begin errors++; $display("FAIL b2b_%0d got=%b/%h want=1/%h", i, done1, f1, exp_f); end
                checks++; if (done4 !== 1'b1 || f4 !== exp_f) begin errors++; $display("FAIL b2b4_%0d got=%b/%h want=1/%h", i, done4, f4, exp_f); end
            end
            if (i < 20) begin
                start = 1'b1; aluop = 3'($urandom_range(0, 3)); a = 16'($urandom); b = 16'($urandom);
                exp_f = model_f(aluop, a, b);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b want=0", done1); end
    endtask

    task automatic test_random;
        int l1, l4, z1, z4, d1, d4, el1, el4; logic [15:0] r1, r4, av, bv, ef; logic e1, e4, ee; logic [2:0] op;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            av = 16'($urandom);
            bv = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 20));
            ef = model_f(op, av, bv);
            el1 = model_lat(op, bv, 1);
            el4 = model_lat(op, bv, 4);
            ee = (op == 3'b111) && !MUL_EN;
            run_op(op, av, bv, l1, l4, r1, r4, e1, e4, z1, z4, d1, d4);
            checks++; if (r1 !== ef || e1 !== ee) begin errors++; $display("FAIL rnd%0d_f op=%0d a=%h b=%h got=%h/%b want=%h/%b", i, op, av, bv, r1, e1, ef, ee); end
            checks++; if (r4 !== ef || e4 !== ee) begin errors++; $display("FAIL rnd%0d_f4 op=%0d a=%h b=%h got=%h/%b want=%h/%b", i, op, av, bv, r4, e4, ef, ee); end
            checks++; if (l1 !== el1 || z1 !== el1 - 1) begin errors++; $display("FAIL rnd%0d_lat op=%0d b=%h got=%0d/%0d want=%0d/%0d", i, op, bv, l1, z1, el1, el1 - 1); end
            checks++; if (l4 !== el4 || z4 !== el4 - 1) begin errors++; $display("FAIL rnd%0d_lat4 op=%0d b=%h got=%0d/%0d want=%0d/%0d", i, op, bv, l4, z4, el4, el4 - 1); end
            checks++; if (d1 !== 1 || d4 !== 1) begin errors++; $display("FAIL rnd%0d_pulses got=%0d/%0d want=1/1", i, d1, d4); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; aluop = 3'b000; a = '0; b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_add_not();
        test_sra();
        test_shift_zero();
        test_busy_drop();
        test_reset_mid();
        test_mul();
        test_step4();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
